// File: rtl/ibex_cheri_cap_lsu_seq_pkg.sv
// rtl/ibex_cheri_cap_lsu_seq_pkg.sv - shared types for the capability load/store sequencer
package ibex_cheri_cap_lsu_seq_pkg;

  typedef enum logic [1:0] {
    CAP_SEQ_IDLE,
    CAP_SEQ_REQ,
    CAP_SEQ_WAIT,
    CAP_SEQ_DONE
  } cap_seq_state_e;

  parameter int unsigned CAP_BEAT_BYTES = 4;

endpackage

// File: rtl/ibex_cheri_cap_lsu_seq.sv
// rtl/ibex_cheri_cap_lsu_seq.sv - splits one tagged capability load/store into 32-bit bus beats
module ibex_cheri_cap_lsu_seq #(
  parameter int unsigned CapWidth = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [CapWidth-1:0] wcap_i,
  input  logic                wtag_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                err_o,
  output logic                misaligned_o,
  output logic [31:0]         err_addr_o,
  output logic [CapWidth-1:0] rcap_o,
  output logic                rtag_o,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic                data_err_i,
  output logic                data_we_o,
  output logic [3:0]          data_be_o,
  output logic [31:0]         data_addr_o,
  output logic [31:0]         data_wdata_o,
  output logic                data_tag_o,
  input  logic [31:0]         data_rdata_i,
  input  logic                data_tag_i
);
  import ibex_cheri_cap_lsu_seq_pkg::*;

  localparam int unsigned Beats  = CapWidth / 32;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned AlignW = $clog2(CapWidth / 8);

  cap_seq_state_e      state_q, state_d;
  logic [BeatW-1:0]    beat_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [CapWidth-1:0] wcap_q;
  logic                wtag_q;
  logic                tag_acc_q;
  logic [CapWidth-1:0] buf_q;
  logic                err_q;
  logic                mis_q;
  logic [31:0]         err_addr_q;

  logic        last_beat;
  logic        misaligned_req;
  logic [31:0] beat_addr;
  logic        in_req;
  logic        in_done;

  assign last_beat      = (beat_q == BeatW'(Beats - 1));
  assign misaligned_req = (addr_i[AlignW-1:0] != '0);
  // Aligned capabilities never cross their own boundary, so a plain add suffices.
  assign beat_addr      = addr_q + 32'(beat_q) * CAP_BEAT_BYTES;
  assign in_req         = (state_q == CAP_SEQ_REQ);
  assign in_done        = (state_q == CAP_SEQ_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CAP_SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAP_SEQ_IDLE: if (req_i) state_d = misaligned_req ? CAP_SEQ_DONE : CAP_SEQ_REQ;
      CAP_SEQ_REQ:  if (data_gnt_i) state_d = CAP_SEQ_WAIT;
      CAP_SEQ_WAIT: begin
        if (data_rvalid_i) state_d = (data_err_i || last_beat) ? CAP_SEQ_DONE : CAP_SEQ_REQ;
      end
      CAP_SEQ_DONE: state_d = CAP_SEQ_IDLE;
      default:      state_d = CAP_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wcap_q     <= '0;
      wtag_q     <= 1'b0;
      tag_acc_q  <= 1'b1;
      buf_q      <= '0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      unique case (state_q)
        CAP_SEQ_IDLE: begin
          if (req_i) begin
            we_q       <= we_i;
            addr_q     <= addr_i;
            wcap_q     <= wcap_i;
            wtag_q     <= wtag_i;
            beat_q     <= '0;
            tag_acc_q  <= 1'b1;
            err_q      <= misaligned_req;
            mis_q      <= misaligned_req;
            err_addr_q <= addr_i;
          end
        end
        CAP_SEQ_WAIT: begin
          if (data_rvalid_i) begin
            if (data_err_i) begin
              err_q      <= 1'b1;
              err_addr_q <= beat_addr;
            end else begin
              if (!we_q) begin
                buf_q[{beat_q, 5'd0} +: 32] <= data_rdata_i;
                tag_acc_q                   <= tag_acc_q & data_tag_i;
              end
              if (!last_beat) beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o      = (state_q == CAP_SEQ_IDLE);
  assign done_o       = in_done;
  assign err_o        = in_done & err_q;
  assign misaligned_o = in_done & mis_q;
  assign err_addr_o   = (in_done && err_q) ? err_addr_q : '0;
  // A failed load must never leak partially assembled data or a stale tag.
  assign rcap_o       = (in_done && !err_q) ? buf_q : '0;
  assign rtag_o       = in_done & ~err_q & tag_acc_q;

  assign data_req_o   = in_req;
  assign data_we_o    = in_req & we_q;
  assign data_be_o    = in_req ? 4'hF : 4'h0;
  assign data_addr_o  = in_req ? beat_addr : '0;
  assign data_wdata_o = in_req ? wcap_q[{beat_q, 5'd0} +: 32] : '0;
  assign data_tag_o   = in_req & we_q & wtag_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   data_rvalid_i |-> (state_q == CAP_SEQ_WAIT));

endmodule

// File: tb/tb_ibex_cheri_cap_lsu_seq.sv
// tb/tb_ibex_cheri_cap_lsu_seq.sv - directed scoreboard bench for the capability sequencer
module tb_ibex_cheri_cap_lsu_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, wtag_i;
  logic [31:0] addr_i;
  logic [63:0] wcap_i;
  logic        ready_o, done_o, err_o, misaligned_o, rtag_o;
  logic [31:0] err_addr_o;
  logic [63:0] rcap_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o, data_tag_o, data_tag_i;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

  always #5 clk_i = ~clk_i;

  ibex_cheri_cap_lsu_seq #(.CapWidth(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wcap_i(wcap_i), .wtag_i(wtag_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
    .misaligned_o(misaligned_o), .err_addr_o(err_addr_o), .rcap_o(rcap_o), .rtag_o(rtag_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_tag_o(data_tag_o),
    .data_rdata_i(data_rdata_i), .data_tag_i(data_tag_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        tag;
  } beat_t;

  typedef struct {
    logic        err;
    logic        mis;
    logic [31:0] err_addr;
    logic [63:0] rcap;
    logic        rtag;
    logic        chk_data;
    int          lat;
  } res_t;

  beat_t       beat_q[$];
  res_t        res_q[$];
  logic [31:0] mem[logic [31:0]];
  logic        mem_tag[logic [31:0]];
  logic [31:0] err_inj_addr = 32'hFFFF_FFFF;
  int          gnt_stall = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Bus slave: optional grant stall on the next beat, read data from mem, rvalid one cycle after grant.
  initial begin
    logic        pend;
    logic [31:0] p_rdata;
    logic        p_tag, p_err, held;
    int          stall;
    beat_t       first, exp;
    pend = 1'b0; held = 1'b0; stall = 0;
    p_rdata = '0; p_tag = 1'b0; p_err = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    data_rdata_i = '0; data_tag_i = 1'b0;
    forever begin
      @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      data_rdata_i = '0; data_tag_i = 1'b0;
      if (!rst_ni) begin
        pend = 1'b0; held = 1'b0; stall = 0;
      end else if (pend) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = p_rdata;
        data_tag_i    = p_tag;
        data_err_i    = p_err;
        pend = 1'b0;
      end else if (data_req_o) begin
        if (!held) begin
          first = '{data_addr_o, data_we_o, data_wdata_o, data_tag_o};
          held  = 1'b1;
        end else begin
          check("stable_addr", 64'(data_addr_o), 64'(first.addr));
          check("stable_wdata", 64'(data_wdata_o), 64'(first.wdata));
          check("stable_we", 64'(data_we_o), 64'(first.we));
          check("stable_tag", 64'(data_tag_o), 64'(first.tag));
        end
        check("be", 64'(data_be_o), 64'h000F);
        if (stall < gnt_stall) begin
          stall++;
        end else begin
          data_gnt_i = 1'b1;
          held = 1'b0; stall = 0; gnt_stall = 0;
          check("beat_expected", 64'(beat_q.size() > 0), 64'd1);
          if (beat_q.size() > 0) begin
            exp = beat_q.pop_front();
            check("beat_addr", 64'(data_addr_o), 64'(exp.addr));
            check("beat_we", 64'(data_we_o), 64'(exp.we));
            check("beat_tag", 64'(data_tag_o), 64'(exp.tag));
            if (exp.we) check("beat_wdata", 64'(data_wdata_o), 64'(exp.wdata));
          end
          p_rdata = mem.exists(data_addr_o) ? mem[data_addr_o] : 32'h0;
          p_tag   = mem_tag.exists(data_addr_o) ? mem_tag[data_addr_o] : 1'b0;
          p_err   = (data_addr_o == err_inj_addr);
          pend    = 1'b1;
        end
      end
    end
  end

  task automatic accept(input logic we, input logic [31:0] addr, input logic [63:0] wcap,
                        input logic wtag);
    @(negedge clk_i);
    check("ready_before", 64'(ready_o), 64'd1);
    req_i = 1'b1; we_i = we; addr_i = addr; wcap_i = wcap; wtag_i = wtag;
    @(posedge clk_i);
    #1;
    req_i = 1'b0; wcap_i = '0; addr_i = '0;
  endtask

  task automatic run_op(input logic we, input logic [31:0] addr, input logic [63:0] wcap,
                        input logic wtag);
    int   n;
    res_t r;
    accept(we, addr, wcap, wtag);
    n = 0;
    while (n < 60) begin
      @(negedge clk_i);
      n++;
      if (done_o) break;
    end
    check("done_seen", 64'(done_o), 64'd1);
    r = res_q.pop_front();
    check("latency", 64'(n), 64'(r.lat));
    check("err", 64'(err_o), 64'(r.err));
    check("misaligned", 64'(misaligned_o), 64'(r.mis));
    if (r.err) check("err_addr", 64'(err_addr_o), 64'(r.err_addr));
    if (r.chk_data) begin
      check("rcap", rcap_o, r.rcap);
      check("rtag", 64'(rtag_o), 64'(r.rtag));
    end
    @(negedge clk_i);
    check("done_pulse", 64'(done_o), 64'd0);
    check("ready_after", 64'(ready_o), 64'd1);
    check("beats_consumed", 64'(beat_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wcap_i = '0; wtag_i = 1'b0;
    mem[32'h1000] = 32'hAAAA_5555; mem_tag[32'h1000] = 1'b1;
    mem[32'h1004] = 32'h1234_5678; mem_tag[32'h1004] = 1'b1;
    mem[32'h4000] = 32'h0BAD_0000; mem_tag[32'h4000] = 1'b1;
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_req", 64'(data_req_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rcap", rcap_o, 64'd0);
    check("rst_rtag", 64'(rtag_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    beat_q.push_back('{32'h1000, 1'b0, 32'h0, 1'b0});
    beat_q.push_back('{32'h1004, 1'b0, 32'h0, 1'b0});
    res_q.push_back('{1'b0, 1'b0, 32'h0, 64'h1234_5678_AAAA_5555, 1'b1, 1'b1, 5});
    run_op(1'b0, 32'h1000, 64'h0, 1'b0);

    mem_tag[32'h1004] = 1'b0;
    beat_q.push_back('{32'h1000, 1'b0, 32'h0, 1'b0});
    beat_q.push_back('{32'h1004, 1'b0, 32'h0, 1'b0});
    res_q.push_back('{1'b0, 1'b0, 32'h0, 64'h1234_5678_AAAA_5555, 1'b0, 1'b1, 5});
    run_op(1'b0, 32'h1000, 64'h0, 1'b0);

    mem_tag[32'h1004] = 1'b1;
    mem[32'h1000] = 32'h0F0F_1E1E;
    beat_q.push_back('{32'h1000, 1'b0, 32'h0, 1'b0});
    beat_q.push_back('{32'h1004, 1'b0, 32'h0, 1'b0});
    res_q.push_back('{1'b0, 1'b0, 32'h0, 64'h1234_5678_0F0F_1E1E, 1'b1, 1'b1, 5});
    run_op(1'b0, 32'h1000, 64'h0, 1'b0);

    gnt_stall = 3;
    beat_q.push_back('{32'h2008, 1'b1, 32'hCAFE_F00D, 1'b1});
    beat_q.push_back('{32'h200C, 1'b1, 32'hDEAD_BEEF, 1'b1});
    res_q.push_back('{1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 8});
    run_op(1'b1, 32'h2008, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);

    res_q.push_back('{1'b1, 1'b1, 32'h3004, 64'h0, 1'b0, 1'b1, 1});
    run_op(1'b0, 32'h3004, 64'h0, 1'b0);

    err_inj_addr = 32'h4004;
    beat_q.push_back('{32'h4000, 1'b0, 32'h0, 1'b0});
    beat_q.push_back('{32'h4004, 1'b0, 32'h0, 1'b0});
    res_q.push_back('{1'b1, 1'b0, 32'h4004, 64'h0, 1'b0, 1'b1, 5});
    run_op(1'b0, 32'h4000, 64'h0, 1'b0);
    repeat (3) @(negedge clk_i);
    check("no_req_after_err", 64'(data_req_o), 64'd0);
    err_inj_addr = 32'hFFFF_FFFF;

    // Abort a load while beat0 is outstanding, then confirm a clean restart.
    beat_q.push_back('{32'h5000, 1'b0, 32'h0, 1'b0});
    accept(1'b0, 32'h5000, 64'h0, 1'b0);
    @(posedge clk_i);
    #1;
    check("in_wait_ready", 64'(ready_o), 64'd0);
    check("in_wait_req", 64'(data_req_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    check("async_rst_req", 64'(data_req_o), 64'd0);
    check("async_rst_ready", 64'(ready_o), 64'd1);
    check("aborted_beats", 64'(beat_q.size()), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    beat_q.push_back('{32'h1000, 1'b0, 32'h0, 1'b0});
    beat_q.push_back('{32'h1004, 1'b0, 32'h0, 1'b0});
    res_q.push_back('{1'b0, 1'b0, 32'h0, 64'h1234_5678_0F0F_1E1E, 1'b1, 1'b1, 5});
    run_op(1'b0, 32'h1000, 64'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
